// File: rtl/ram_bank_clr.sv
// Dual-port (one write, one read) synchronous RAM with byte-lane write enables,
// registered read with valid flag, and a post-reset clear engine.
module ram_bank_clr #(
  parameter int BUS_WIDTH     = 16,
  parameter int LANE_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 2,
  parameter int WRITE_FIRST   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDRESS_WIDTH-1:0]        wa,
  input  logic                            we,
  input  logic [BUS_WIDTH/LANE_WIDTH-1:0] wbe,
  input  logic [BUS_WIDTH-1:0]            wd,
  input  logic [ADDRESS_WIDTH-1:0]        ra,
  input  logic                            re,
  output logic [BUS_WIDTH-1:0]            rd,
  output logic                            rv,
  output logic                            busy
);

  localparam int LANES = BUS_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   cp_q, cp_d;
  logic [BUS_WIDTH-1:0]       mem_q [DEPTH];
  logic [BUS_WIDTH-1:0]       rd_q;
  logic                       rv_q;

  logic                       clr_en_s;
  logic                       wr_en_s;
  logic                       rd_en_s;
  logic                       busy_s;
  logic [BUS_WIDTH-1:0]       wr_word_s;
  logic [BUS_WIDTH-1:0]       rd_word_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cp_q    <= '0;
    end else begin
      state_q <= state_d;
      cp_q    <= cp_d;
    end
  end

  // The clear pointer only wraps on the edge that leaves CLEAR.
  always_comb begin
    state_d = state_q;
    cp_d    = cp_q;
    case (state_q)
      CLEAR: begin
        cp_d = cp_q + ADDRESS_WIDTH'(1);
        if (&cp_q) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        cp_d    = '0;
      end
    endcase
  end

  always_comb begin
    clr_en_s = 1'b0;
    wr_en_s  = 1'b0;
    rd_en_s  = 1'b0;
    busy_s   = 1'b1;
    case (state_q)
      CLEAR: begin
        clr_en_s = 1'b1;
        busy_s   = 1'b1;
      end
      RUN: begin
        wr_en_s = we;
        rd_en_s = re;
        busy_s  = 1'b0;
      end
      default: begin
        busy_s = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_word_s = mem_q[wa];
    for (int i = 0; i < LANES; i++) begin
      if (wbe[i]) begin
        wr_word_s[i*LANE_WIDTH +: LANE_WIDTH] = wd[i*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        wr_word_s[i*LANE_WIDTH +: LANE_WIDTH] = mem_q[wa][i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_comb begin
    if ((WRITE_FIRST != 0) && wr_en_s && (wa == ra)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_q[ra];
    end
  end

  // A reset edge discards both the clear step and any pending write.
  always_ff @(posedge clk) begin
    if (!rst && clr_en_s) begin
      mem_q[cp_q] <= '0;
    end else if (!rst && wr_en_s) begin
      mem_q[wa] <= wr_word_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= rd_en_s;
      if (rd_en_s) begin
        rd_q <= rd_word_s;
      end
    end
  end

  assign rd   = rd_q;
  assign rv   = rv_q;
  assign busy = busy_s;

endmodule

// File: tb/tb_ram_bank_clr.sv
// Directed bench for ram_bank_clr: two instances (read-first and write-first)
// share stimulus and are checked every cycle against a behavioural model.
module tb_ram_bank_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wa, ra;
  logic        we, re;
  logic [1:0]  wbe;
  logic [15:0] wd;
  logic [15:0] rd0, rd1;
  logic        rv0, rv1, busy0, busy1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit started   = 1'b0;

  always #5 clk = ~clk;

  ram_bank_clr #(.BUS_WIDTH(16), .LANE_WIDTH(8), .ADDRESS_WIDTH(2), .WRITE_FIRST(0)) u_rf (
    .clk(clk), .rst(rst), .wa(wa), .we(we), .wbe(wbe), .wd(wd),
    .ra(ra), .re(re), .rd(rd0), .rv(rv0), .busy(busy0)
  );

  ram_bank_clr #(.BUS_WIDTH(16), .LANE_WIDTH(8), .ADDRESS_WIDTH(2), .WRITE_FIRST(1)) u_wf (
    .clk(clk), .rst(rst), .wa(wa), .we(we), .wbe(wbe), .wd(wd),
    .ra(ra), .re(re), .rd(rd1), .rv(rv1), .busy(busy1)
  );

  // Behavioural model: a plain word array plus a count of clear edges left.
  logic [15:0] m [4];
  int          clr_left = -1;
  logic [15:0] exp_rd0, exp_rd1;
  logic        exp_rv, exp_busy;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] mask;
    mask = {(be[1] ? 8'hFF : 8'h00), (be[0] ? 8'hFF : 8'h00)};
    return (old & ~mask) | (d & mask);
  endfunction

  always @(posedge clk) begin
    logic [15:0] nw;
    if (rst) begin
      clr_left = 4;
      exp_rd0  = 16'h0000;
      exp_rd1  = 16'h0000;
      exp_rv   = 1'b0;
      exp_busy = 1'b1;
    end else if (clr_left > 0) begin
      m[4 - clr_left] = 16'h0000;
      clr_left = clr_left - 1;
      exp_busy = (clr_left > 0);
      exp_rv   = 1'b0;
    end else begin
      nw     = merge(m[wa], wd, wbe);
      exp_rv = re;
      if (re) begin
        exp_rd0 = m[ra];
        exp_rd1 = (we && (wa == ra)) ? nw : m[ra];
      end
      if (we) m[wa] = nw;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("rd_rf",   rd0,            exp_rd0);
      check("rd_wf",   rd1,            exp_rd1);
      check("rv_rf",   {15'd0, rv0},   {15'd0, exp_rv});
      check("rv_wf",   {15'd0, rv1},   {15'd0, exp_rv});
      check("busy_rf", {15'd0, busy0}, {15'd0, exp_busy});
      check("busy_wf", {15'd0, busy1}, {15'd0, exp_busy});
    end
  end

  // Caller sits at a negedge; inputs are applied, then one full cycle elapses.
  task automatic drive(input logic r, input logic w, input logic [1:0] a_w,
                       input logic [1:0] be, input logic [15:0] d,
                       input logic rdn, input logic [1:0] a_r);
    rst = r; we = w; wa = a_w; wbe = be; wd = d; re = rdn; ra = a_r;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 2'b00, 16'h0000, 1'b0, 2'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b0, 1'b1, a, be, d, 1'b0, 2'd0);
  endtask

  task automatic rdr(input logic [1:0] a);
    drive(1'b0, 1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, a);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wa = 2'd0; ra = 2'd0; wbe = 2'b00; wd = 16'h0000;
    @(negedge clk);

    // 1. Clear sequence
    drive(1'b1, 1'b0, 2'd0, 2'b00, 16'h0000, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 2'd0, 2'b00, 16'h0000, 1'b0, 2'd0);
    started = 1'b1;
    check("reset_busy", {15'd0, busy0}, 16'h0001);
    check("reset_rd",   rd0,            16'h0000);
    check("reset_rv",   {15'd0, rv0},   16'h0000);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("clear_busy", {15'd0, busy0}, (i < 3) ? 16'h0001 : 16'h0000);
    end
    for (int i = 0; i < 4; i++) begin
      rdr(2'(i));
      check("clear_rd", rd0, 16'h0000);
      check("clear_rv", {15'd0, rv0}, 16'h0001);
    end
    idle();
    check("clear_rv_drop", {15'd0, rv0}, 16'h0000);

    // 2. Basic write/read
    wr(2'd2, 16'hBEEF, 2'b11);
    rdr(2'd2);
    check("basic_rd",   rd0,           16'hBEEF);
    check("basic_rv",   {15'd0, rv0},  16'h0001);
    check("model_pin1", exp_rd0,       16'hBEEF);
    idle();
    check("basic_hold", rd0,           16'hBEEF);
    check("basic_rv0",  {15'd0, rv0},  16'h0000);

    // 3. Byte lanes
    wr(2'd2, 16'h1234, 2'b01);
    rdr(2'd2);
    check("lane_lo",    rd0, 16'hBE34);
    wr(2'd2, 16'h5678, 2'b10);
    rdr(2'd2);
    check("lane_hi",    rd0, 16'h5634);
    wr(2'd2, 16'hFFFF, 2'b00);
    rdr(2'd2);
    check("lane_none",  rd0, 16'h5634);
    check("model_pin2", exp_rd1, 16'h5634);

    // 4. Collision
    wr(2'd3, 16'h00AA, 2'b11);
    drive(1'b0, 1'b1, 2'd3, 2'b11, 16'h5555, 1'b1, 2'd3);
    check("coll_rf",    rd0, 16'h00AA);
    check("coll_wf",    rd1, 16'h5555);
    check("model_pin3", exp_rd0, 16'h00AA);
    rdr(2'd3);
    check("coll_rf_after", rd0, 16'h5555);
    check("coll_wf_after", rd1, 16'h5555);

    // 5. Reset mid-operation
    wr(2'd1, 16'h1111, 2'b11);
    drive(1'b1, 1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd1);
    check("midrst_rv",   {15'd0, rv0},   16'h0000);
    check("midrst_rd",   rd1,            16'h0000);
    check("midrst_busy", {15'd0, busy1}, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'd0, 2'b11, 16'hFFFF, 1'b1, 2'd0);
      check("busy_ignore_rv", {15'd0, rv0}, 16'h0000);
    end
    check("midrst_busy_end", {15'd0, busy0}, 16'h0000);
    rdr(2'd1);
    check("midrst_a1", rd0, 16'h0000);
    rdr(2'd0);
    check("midrst_a0", rd0, 16'h0000);

    // 6. Streaming reads
    wr(2'd0, 16'h0A0A, 2'b11);
    wr(2'd1, 16'h0B0B, 2'b11);
    wr(2'd2, 16'h0C0C, 2'b11);
    wr(2'd3, 16'h0D0D, 2'b11);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] want;
      rdr(2'(i));
      want = {4'h0, 4'(10 + i), 4'h0, 4'(10 + i)};
      check("stream_rd", rd0, want);
      check("stream_rv", {15'd0, rv1}, 16'h0001);
    end
    idle();
    check("stream_end_rv", {15'd0, rv0}, 16'h0000);
    idle();

    started = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_bank_clr.md
Name: ram_bank_clr

Overview:
Parametrised synchronous RAM with a separate write port and read port, byte-lane write enables, and a registered read with a valid flag. A built-in clear engine zeroes every word after reset and reports progress on a busy flag. It succeeds the single-port store/load RAM and serves as the general scratch/buffer memory in the datapath.

Parameters:
BUS_WIDTH, 16, data word width in bits; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 8, bits per write-enable lane; LANES = BUS_WIDTH/LANE_WIDTH.
ADDRESS_WIDTH, 2, address bits; DEPTH = 2**ADDRESS_WIDTH words.
WRITE_FIRST, 0, read/write same-address collision policy: 0 returns old data, 1 returns new data.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  synchronous, active-high reset.
wa  input  ADDRESS_WIDTH  write address.
we  input  1  write strobe.
wbe  input  LANES  per-lane write enable; bit i covers data bits [i*LANE_WIDTH +: LANE_WIDTH].
wd  input  BUS_WIDTH  write data.
ra  input  ADDRESS_WIDTH  read address.
re  input  1  read strobe.
rd  output  BUS_WIDTH  registered read data.
rv  output  1  rd valid; high for exactly one cycle per accepted read.
busy  output  1  clear engine active; all accesses are ignored while high.

Behaviour:
- State machine has two states, CLEAR and RUN, plus a clear pointer cp of ADDRESS_WIDTH bits.
- Reset: an edge sampling rst=1 sets state to CLEAR, cp=0, rd=0, rv=0, busy=1. While rst is held, the block stays in CLEAR with cp=0 and clears nothing.
- CLEAR with rst=0: each edge writes mem[cp]=0 and increments cp. The edge that clears address DEPTH-1 sets state to RUN and busy=0. busy therefore stays high for exactly DEPTH edges after rst falls.
- While busy=1, we and re are ignored: no memory update, rv=0, rd holds 0.
- RUN write: on an edge with we=1, every lane with wbe[i]=1 takes the matching lane of wd; other lanes keep their contents. we=1 with wbe=0 changes nothing.
- RUN read: on an edge with re=1, rd takes mem[ra] and rv=1 after that edge, giving 1-cycle latency. On an edge with re=0, rd holds its value and rv=0.
- Back-to-back reads give one result per cycle; rv stays high continuously.
- Collision (we=1, re=1, wa==ra on the same edge):
  - WRITE_FIRST=0: rd gets the pre-write word.
  - WRITE_FIRST=1: rd gets the merged word, with enabled lanes from wd and the rest from the old word.
- Different addresses on the same edge are fully independent.
- Addresses cover the full 0..DEPTH-1 range with no out-of-range case. cp wraps only at the CLEAR-to-RUN transition.
- rst asserted mid-operation (RUN or CLEAR) overrides everything on that edge:
  - any in-flight read result is dropped (rv=0, rd=0);
  - the write on that edge is discarded;
  - clearing restarts from address 0.
- Memory contents are undefined only before the first reset; the bench must reset first.

Test Plan:
All scenarios use BUS_WIDTH=16, LANE_WIDTH=8, ADDRESS_WIDTH=2 (DEPTH=4) unless stated.
1. Clear sequence: pulse rst for 2 cycles, then low -> busy=1 for exactly 4 edges after rst falls, then 0. Reads of addresses 0..3 return 0x0000, each with a single-cycle rv pulse one cycle after re.
2. Basic write/read: write wa=2, wd=0xBEEF, wbe=11; next cycle read ra=2 -> rd=0xBEEF, rv=1 one cycle after re. Following cycle with re=0 -> rd stays 0xBEEF, rv=0.
3. Byte lanes: on top of address 2 holding 0xBEEF, write 0x1234 with wbe=01 -> read 0xBE34. Then write 0x5678 with wbe=10 -> read 0x5634. A write with wbe=00 leaves the word at 0x5634.
4. Collision: address 3 holds 0x00AA; on one edge write 0x5555 (wbe=11) and read address 3.
   - WRITE_FIRST=0 instance: rd=0x00AA, and a follow-up read returns 0x5555.
   - WRITE_FIRST=1 instance: rd=0x5555 immediately.
5. Reset mid-operation: write 0x1111 to address 1; assert rst for 1 cycle on the same edge as re=1 for address 1 -> rv stays 0. During busy, drive we=1, wa=0, wd=0xFFFF -> ignored. After busy falls, address 1 reads 0x0000 and address 0 reads 0x0000.
6. Streaming reads: fill addresses 0..3 with 0x0A0A, 0x0B0B, 0x0C0C, 0x0D0D, then assert re for 4 consecutive cycles with ra=0,1,2,3 -> rv high for 4 consecutive cycles and rd=0x0A0A, 0x0B0B, 0x0C0C, 0x0D0D in order.
